// File: rtl/sum_accumulator_if.sv
// Stream interface for sum_accumulator: beat input and frame-result output.
// Both valid/ready handshakes share one bundle.
interface sum_accumulator_if #(
  parameter int IN_W  = 32,
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sum;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_sum, flush, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, flush, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface

// File: rtl/sum_accumulator.sv
// Frame accumulator: sums a beat stream into a wide register and
// emits total, beat count and sticky carry once per frame.
module sum_accumulator #(
  parameter int IN_W      = 32,
  parameter int ACC_W     = 40,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input logic clk,
  input logic rst,
  sum_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic [CNT_W-1:0] cnt_nx;
  logic             last;

  always_comb begin
    ext          = ACC_W'(bus.in_sum);
    {carry, sum} = {1'b0, acc} + {1'b0, ext};
    cnt_nx       = cnt + 1'b1;
    last         = (cnt_nx == CNT_W'(FRAME_LEN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc <= ext;
            cnt <= CNT_W'(1);
            ovf <= 1'b0;
            if (FRAME_LEN == 1 || bus.flush)
              state <= HOLD;
            else
              state <= ACCUM;
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            acc <= sum;
            cnt <= cnt_nx;
            ovf <= ovf | carry;
            if (last || bus.flush)
              state <= HOLD;
          end else if (bus.flush) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags decode registered state only.
  assign bus.in_ready  = (state != HOLD);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_acc   = acc;
  assign bus.out_count = cnt;
  assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: default 40-bit instance plus a
// 33-bit, 4-beat instance for the carry case.
module tb_sum_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sum_accumulator_if #(.IN_W(32), .ACC_W(40), .CNT_W(8)) b();
  sum_accumulator_if #(.IN_W(32), .ACC_W(33), .CNT_W(8)) c();

  sum_accumulator #(
    .IN_W(32), .ACC_W(40), .FRAME_LEN(8), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(b.slave)
  );

  sum_accumulator #(
    .IN_W(32), .ACC_W(33), .FRAME_LEN(4), .CNT_W(8)
  ) dut33 (
    .clk(clk), .rst(rst), .bus(c.slave)
  );

  typedef struct {
    logic [39:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic drv(input logic v, input logic [31:0] s,
                     input logic f, input logic r);
    b.in_valid  = v;
    b.in_sum    = s;
    b.flush     = f;
    b.out_ready = r;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if ({b.in_ready, b.out_valid, b.out_acc, b.out_count, b.out_ovf}
        !== {1'b1, 1'b0, 40'd0, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got rdy=%b vld=%b acc=%h cnt=%0d ovf=%b",
               b.in_ready, b.out_valid, b.out_acc, b.out_count,
               b.out_ovf);
    end
    vectors++;
    if ({c.in_ready, c.out_valid, c.out_acc, c.out_count, c.out_ovf}
        !== {1'b1, 1'b0, 33'd0, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset33: got rdy=%b vld=%b acc=%h",
               c.in_ready, c.out_valid, c.out_acc);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [39:0] a = '0;
    exp_t e;
    for (int i = 1; i <= 8; i++) begin
      vectors++;
      if ({b.in_ready, b.out_valid} !== 2'b10) begin
        miscompares++;
        $display("FAIL b2b_beat%0d: got rdy/vld=%b%b want 10",
                 i, b.in_ready, b.out_valid);
      end
      drv(1'b1, 32'(i), 1'b0, 1'b0);
      a += 40'(i);
    end
    sbq.push_back('{a, 8'd8, 1'b0});
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    e = sbq.pop_front();
    vectors++;
    if ({b.out_valid, b.in_ready, b.out_acc, b.out_count, b.out_ovf}
        !== {1'b1, 1'b0, e.acc, e.cnt, e.ovf}) begin
      miscompares++;
      $display("FAIL b2b_result: got vld=%b rdy=%b acc=%0d cnt=%0d ovf=%b want acc=%0d cnt=%0d",
               b.out_valid, b.in_ready, b.out_acc, b.out_count,
               b.out_ovf, e.acc, e.cnt);
    end
    drv(1'b0, 32'h0, 1'b0, 1'b1);
    vectors++;
    if ({b.out_valid, b.in_ready, b.out_count} !== {2'b01, 8'd0}) begin
      miscompares++;
      $display("FAIL b2b_release: got vld=%b rdy=%b cnt=%0d",
               b.out_valid, b.in_ready, b.out_count);
    end
  endtask

  task automatic test_overflow;
    logic [33:0] t;
    logic [32:0] a = '0;
    logic        o = 1'b0;
    exp_t        e;
    for (int i = 0; i < 4; i++) begin
      c.in_valid = 1'b1;
      c.in_sum   = 32'hFFFF_FFFF;
      @(negedge clk);
      t = {1'b0, a} + 34'(32'hFFFF_FFFF);
      o = o | t[33];
      a = t[32:0];
    end
    c.in_valid = 1'b0;
    sbq.push_back('{40'(a), 8'd4, o});
    e = sbq.pop_front();
    vectors++;
    if ({c.out_valid, c.out_acc, c.out_count, c.out_ovf}
        !== {1'b1, e.acc[32:0], e.cnt, e.ovf}) begin
      miscompares++;
      $display("FAIL ovf33: got vld=%b acc=%h cnt=%0d ovf=%b want acc=%h cnt=%0d ovf=%b",
               c.out_valid, c.out_acc, c.out_count, c.out_ovf,
               e.acc[32:0], e.cnt, e.ovf);
    end
    c.out_ready = 1'b1;
    @(negedge clk);
    c.out_ready = 1'b0;
    vectors++;
    if ({c.out_valid, c.in_ready, c.out_ovf} !== 3'b010) begin
      miscompares++;
      $display("FAIL ovf33_release: got vld=%b rdy=%b ovf=%b",
               c.out_valid, c.in_ready, c.out_ovf);
    end
  endtask

  task automatic test_flush;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      drv(1'b1, 32'h1FFFE, 1'b0, 1'b0);
      if (k == 0) begin
        drv(1'b1, 32'h1, 1'b1, 1'b0);
      end else begin
        drv(1'b1, 32'h1, 1'b0, 1'b0);
        drv(1'b0, 32'h0, 1'b1, 1'b0);
      end
      sbq.push_back('{40'h1FFFF, 8'd2, 1'b0});
      e = sbq.pop_front();
      vectors++;
      if ({b.out_valid, b.out_acc, b.out_count, b.out_ovf}
          !== {1'b1, e.acc, e.cnt, e.ovf}) begin
        miscompares++;
        $display("FAIL flush%0d: got vld=%b acc=%h cnt=%0d want acc=%h cnt=%0d",
                 k, b.out_valid, b.out_acc, b.out_count, e.acc, e.cnt);
      end
      drv(1'b0, 32'h0, 1'b0, 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      drv(1'b0, 32'h0, 1'b1, 1'b0);
      vectors++;
      if ({b.out_valid, b.in_ready, b.out_count} !== {2'b01, 8'd0}) begin
        miscompares++;
        $display("FAIL flush_idle%0d: got vld=%b rdy=%b cnt=%0d",
                 k, b.out_valid, b.in_ready, b.out_count);
      end
    end
    drv(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    logic [39:0] a = '0;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 32'(10 * i + 3), 1'b0, 1'b0);
      a += 40'(10 * i + 3);
    end
    sbq.push_back('{a, 8'd8, 1'b0});
    e = sbq.pop_front();
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if ({b.out_valid, b.in_ready, b.out_acc, b.out_count, b.out_ovf}
          !== {1'b1, 1'b0, e.acc, e.cnt, e.ovf}) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b acc=%0d cnt=%0d want acc=%0d cnt=%0d",
                 k, b.out_valid, b.in_ready, b.out_acc, b.out_count,
                 e.acc, e.cnt);
      end
      drv(1'b1, $urandom, 1'b0, 1'b0);
    end
    drv(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    vectors++;
    if ({b.out_valid, b.in_ready, b.out_count} !== {2'b01, 8'd0}) begin
      miscompares++;
      $display("FAIL bp_release: got vld=%b rdy=%b cnt=%0d",
               b.out_valid, b.in_ready, b.out_count);
    end
    a = '0;
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 32'd5, 1'b0, 1'b0);
      a += 40'd5;
    end
    sbq.push_back('{a, 8'd8, 1'b0});
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    e = sbq.pop_front();
    vectors++;
    if ({b.out_valid, b.out_acc, b.out_count} !== {1'b1, e.acc, e.cnt}) begin
      miscompares++;
      $display("FAIL bp_next: got vld=%b acc=%0d cnt=%0d want acc=%0d cnt=%0d",
               b.out_valid, b.out_acc, b.out_count, e.acc, e.cnt);
    end
    drv(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    for (int i = 0; i < 3; i++) drv(1'b1, 32'hFFFF, 1'b0, 1'b0);
    rst = 1'b1;
    drv(1'b1, 32'hFFFF, 1'b1, 1'b0);
    rst = 1'b0;
    vectors++;
    if ({b.in_ready, b.out_valid, b.out_acc, b.out_count, b.out_ovf}
        !== {1'b1, 1'b0, 40'd0, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_mid: got rdy=%b vld=%b acc=%h cnt=%0d ovf=%b",
               b.in_ready, b.out_valid, b.out_acc, b.out_count,
               b.out_ovf);
    end
    for (int i = 0; i < 8; i++) drv(1'b1, 32'h1, 1'b0, 1'b0);
    sbq.push_back('{40'd8, 8'd8, 1'b0});
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    e = sbq.pop_front();
    vectors++;
    if ({b.out_valid, b.out_acc, b.out_count, b.out_ovf}
        !== {1'b1, e.acc, e.cnt, e.ovf}) begin
      miscompares++;
      $display("FAIL rst_mid_next: got vld=%b acc=%0d cnt=%0d want acc=%0d cnt=%0d",
               b.out_valid, b.out_acc, b.out_count, e.acc, e.cnt);
    end
    drv(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_gapped;
    logic [39:0] a = '0;
    logic [31:0] v;
    int   n = 0;
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0 && n < 8) begin
        v = (n % 2 == 0) ? 32'h0000_FFFF : 32'h1;
        drv(1'b1, v, 1'b0, 1'b0);
        a += 40'(v);
        n++;
        if (n == 8) sbq.push_back('{a, 8'd8, 1'b0});
      end else begin
        drv(1'b0, $urandom, 1'b0, 1'b0);
      end
      vectors++;
      if (b.out_valid !== (n == 8)) begin
        miscompares++;
        $display("FAIL gap_cyc%0d: got vld=%b want %b",
                 i, b.out_valid, (n == 8));
      end
    end
    e = sbq.pop_front();
    vectors++;
    if ({b.out_acc, b.out_count, b.out_ovf} !== {e.acc, e.cnt, e.ovf}) begin
      miscompares++;
      $display("FAIL gap_result: got acc=%h cnt=%0d want acc=%h cnt=%0d",
               b.out_acc, b.out_count, e.acc, e.cnt);
    end
    drv(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    c.in_valid  = 1'b0;
    c.in_sum    = '0;
    c.flush     = 1'b0;
    c.out_ready = 1'b0;
    test_reset;
    test_back_to_back;
    test_overflow;
    test_flush;
    test_backpressure;
    test_reset_mid;
    test_gapped;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
